// File: rtl/mac_pkg.sv
// Shared types and width helpers for the pairwise multiply-accumulate sequencer.
package mac_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_DONE} state_e;

  function automatic int unsigned f_n_terms(input int unsigned n_words);
    return (n_words + 1) / 2;
  endfunction

  // Product width plus enough headroom to sum every term without overflow.
  function automatic int unsigned f_nb_out(input int unsigned n_words, input int unsigned nb_data);
    return 2 * nb_data + $clog2(f_n_terms(n_words));
  endfunction

endpackage

// File: rtl/mac_pair_sequencer_if.sv
// Vector-in / result-out handshake bundle for mac_pair_sequencer.
interface mac_pair_sequencer_if
  import mac_pkg::*;
#(
  parameter int unsigned N_WORDS = 12,
  parameter int unsigned NB_DATA = 8
);
  localparam int unsigned NB_OUT = f_nb_out(N_WORDS, NB_DATA);

  logic [N_WORDS*NB_DATA-1:0] i_data;
  logic                       i_valid;
  logic                       o_ready;
  logic                       i_abort;
  logic signed [NB_OUT-1:0]   o_data;
  logic                       o_valid;
  logic                       i_ready;
  logic                       o_busy;

  modport master (
    output i_data, i_valid, i_abort, i_ready,
    input  o_ready, o_data, o_valid, o_busy
  );

  modport slave (
    input  i_data, i_valid, i_abort, i_ready,
    output o_ready, o_data, o_valid, o_busy
  );

endinterface

// File: rtl/mac_unit.sv
// Registered signed multiply-add: acc <= acc + sext(a*b), with clear taking priority over enable.
module mac_unit #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OUT  = 19
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  logic                      en_i,
  input  logic signed [NB_DATA-1:0] a_i,
  input  logic signed [NB_DATA-1:0] b_i,
  output logic signed [NB_OUT-1:0]  acc_o
);

  logic signed [2*NB_DATA-1:0] a_ext;
  logic signed [2*NB_DATA-1:0] b_ext;
  logic signed [2*NB_DATA-1:0] prod;
  logic signed [NB_OUT-1:0]    acc_q;
  logic signed [NB_OUT-1:0]    acc_d;

  assign a_ext = (2*NB_DATA)'(a_i);
  assign b_ext = (2*NB_DATA)'(b_i);
  assign prod  = a_ext * b_ext;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + NB_OUT'(prod);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mac_pair_sequencer.sv
// Sums w[2k]*w[2k+1] over one captured vector using a single shared multiply-add,
// one term per clock, with valid/ready on both sides and a synchronous abort.
module mac_pair_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned N_WORDS = 12,
  parameter int unsigned NB_DATA = 8
) (
  input logic                 clock,
  input logic                 reset,
  mac_pair_sequencer_if.slave bus
);

  localparam int unsigned N_TERMS = f_n_terms(N_WORDS);
  localparam int unsigned NB_OUT  = f_nb_out(N_WORDS, NB_DATA);
  localparam int unsigned NB_CNT  = $clog2(N_TERMS) + 1;
  localparam int unsigned NB_PAD  = 2 * N_TERMS * NB_DATA;
  localparam bit          ODD     = (N_WORDS % 2) == 1;

  localparam logic [NB_CNT-1:0]         LAST_CNT = NB_CNT'(N_TERMS - 1);
  localparam logic signed [NB_DATA-1:0] ONE      = {{(NB_DATA-1){1'b0}}, 1'b1};

  state_e                     state_q;
  logic [N_WORDS*NB_DATA-1:0] vec_q;
  logic [NB_CNT-1:0]          cnt_q;
  logic                       ready_q;
  logic                       valid_q;
  logic                       busy_q;

  logic                       accept;
  logic                       acc_clr;
  logic                       acc_en;
  logic [NB_PAD-1:0]          vec_pad;
  logic signed [NB_DATA-1:0]  op_a;
  logic signed [NB_DATA-1:0]  op_b;
  logic signed [NB_OUT-1:0]   acc;

  assign accept  = (state_q == ST_IDLE) && ready_q && bus.i_valid && !bus.i_abort;
  assign acc_clr = bus.i_abort || accept;
  assign acc_en  = (state_q == ST_MAC);

  // Lone trailing word goes through the multiplier as w*1, which is its sign extension.
  always_comb begin
    vec_pad                       = '0;
    vec_pad[N_WORDS*NB_DATA-1:0]  = vec_q;
    op_a                          = '0;
    op_b                          = '0;
    for (int k = 0; k < N_TERMS; k++) begin
      if (cnt_q == NB_CNT'(k)) begin
        op_a = vec_pad[2*k*NB_DATA +: NB_DATA];
        if (ODD && (k == N_TERMS - 1)) begin
          op_b = ONE;
        end else begin
          op_b = vec_pad[(2*k+1)*NB_DATA +: NB_DATA];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (bus.i_abort) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            vec_q   <= bus.i_data;
            cnt_q   <= '0;
            state_q <= ST_MAC;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_MAC: begin
          cnt_q <= cnt_q + NB_CNT'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= ST_DONE;
            valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.i_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  mac_unit #(
    .NB_DATA (NB_DATA),
    .NB_OUT  (NB_OUT)
  ) u_mac_unit (
    .clk_i  (clock),
    .rst_ni (reset),
    .clr_i  (acc_clr),
    .en_i   (acc_en),
    .a_i    (op_a),
    .b_i    (op_b),
    .acc_o  (acc)
  );

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_data  = acc;

endmodule

// File: tb/tb_mac_pair_sequencer.sv
// Directed bench for mac_pair_sequencer: a 12-word and a 5-word instance sharing clock and reset.
module tb_mac_pair_sequencer;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  mac_pair_sequencer_if #(.N_WORDS(12), .NB_DATA(8)) bus12 ();
  mac_pair_sequencer_if #(.N_WORDS(5),  .NB_DATA(8)) bus5 ();

  mac_pair_sequencer #(.N_WORDS(12), .NB_DATA(8)) dut12 (
    .clock (clock),
    .reset (reset),
    .bus   (bus12)
  );

  mac_pair_sequencer #(.N_WORDS(5), .NB_DATA(8)) dut5 (
    .clock (clock),
    .reset (reset),
    .bus   (bus5)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] fill12(input logic [7:0] w);
    logic [95:0] v;
    for (int k = 0; k < 12; k++) v[k*8 +: 8] = w;
    return v;
  endfunction

  // Presents one vector for a single accept edge; returns at the negedge after it.
  task automatic send12(input logic [95:0] v);
    @(negedge clock);
    check("ready_before_accept", bus12.o_ready, 1);
    bus12.i_data  = v;
    bus12.i_valid = 1'b1;
    @(negedge clock);
    bus12.i_valid = 1'b0;
  endtask

  // Clocks counted from the accept edge (inclusive) until o_valid is seen; bounded.
  task automatic wait12(output int lat);
    lat = 1;
    while (!bus12.o_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run12(input string tag, input logic [95:0] v, input longint exp);
    int lat;
    send12(v);
    wait12(lat);
    check(tag, bus12.o_data, exp);
    @(negedge clock);
  endtask

  initial begin
    int          lat;
    int          gap;
    logic        seen;
    logic [95:0] v;
    logic [39:0] v5;

    reset         = 1'b0;
    bus12.i_data  = '0;
    bus12.i_valid = 1'b0;
    bus12.i_abort = 1'b0;
    bus12.i_ready = 1'b1;
    bus5.i_data   = '0;
    bus5.i_valid  = 1'b0;
    bus5.i_abort  = 1'b0;
    bus5.i_ready  = 1'b1;

    repeat (2) @(negedge clock);
    check("rst_ready", bus12.o_ready, 0);
    check("rst_valid", bus12.o_valid, 0);
    check("rst_busy",  bus12.o_busy,  0);
    check("rst_data",  bus12.o_data,  0);
    reset = 1'b1;
    @(negedge clock);
    check("ready_after_release", bus12.o_ready, 1);

    // All ones: latency and one-clock valid pulse.
    send12(fill12(8'd1));
    check("busy_in_mac",  bus12.o_busy,  1);
    check("ready_in_mac", bus12.o_ready, 0);
    wait12(lat);
    check("ones_latency", lat, 7);
    check("ones_data", bus12.o_data, 6);
    @(negedge clock);
    check("valid_pulse", bus12.o_valid, 0);
    check("ready_back",  bus12.o_ready, 1);

    run12("all_min", fill12(8'h80), 98304);
    run12("all_max", fill12(8'h7f), 96774);
    v = '0;
    v[7:0]  = 8'h80;
    v[15:8] = 8'h7f;
    run12("min_times_max", v, -16256);
    for (int k = 0; k < 12; k++) v[k*8 +: 8] = 8'(k + 1);
    run12("ramp_1_to_12", v, 322);

    // Back-to-back with valid and ready held high.
    @(negedge clock);
    bus12.i_data  = fill12(8'd2);
    bus12.i_valid = 1'b1;
    wait12(lat);
    check("tput_first_data", bus12.o_data, 24);
    gap = 0;
    do begin
      @(negedge clock);
      gap++;
    end while (!bus12.o_valid && gap < 40);
    bus12.i_valid = 1'b0;
    check("tput_interval", gap, 8);
    check("tput_second_data", bus12.o_data, 24);
    @(negedge clock);

    // Consumer stall in DONE while a new vector is offered.
    bus12.i_ready = 1'b0;
    send12(fill12(8'd1));
    wait12(lat);
    bus12.i_data  = fill12(8'd3);
    bus12.i_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("stall_valid", bus12.o_valid, 1);
      check("stall_data",  bus12.o_data,  6);
      check("stall_ready", bus12.o_ready, 0);
    end
    bus12.i_valid = 1'b0;
    bus12.i_ready = 1'b1;
    @(negedge clock);
    check("stall_release_valid", bus12.o_valid, 0);
    check("stall_release_ready", bus12.o_ready, 1);
    check("stall_release_busy",  bus12.o_busy,  0);
    check("idle_holds_data",     bus12.o_data,  6);

    // Abort while the counter sits at 3.
    send12(fill12(8'd1));
    repeat (3) @(negedge clock);
    bus12.i_abort = 1'b1;
    @(negedge clock);
    bus12.i_abort = 1'b0;
    check("abort_busy",  bus12.o_busy,  0);
    check("abort_ready", bus12.o_ready, 1);
    check("abort_valid", bus12.o_valid, 0);
    check("abort_data",  bus12.o_data,  0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (bus12.o_valid) seen = 1'b1;
    end
    check("abort_no_valid", seen, 0);

    // Abort beats accept in the same cycle.
    bus12.i_data  = fill12(8'd5);
    bus12.i_valid = 1'b1;
    bus12.i_abort = 1'b1;
    @(negedge clock);
    bus12.i_valid = 1'b0;
    bus12.i_abort = 1'b0;
    check("abort_vs_accept_busy", bus12.o_busy, 0);
    run12("after_abort_twos", fill12(8'd2), 24);

    // Odd word count: lone last word.
    @(negedge clock);
    check("n5_width", $bits(bus5.o_data), 18);
    check("n5_ready", bus5.o_ready, 1);
    v5 = '0;
    v5[7:0]   = 8'd2;
    v5[15:8]  = 8'd3;
    v5[23:16] = 8'd4;
    v5[31:24] = 8'd5;
    v5[39:32] = 8'hf9;
    bus5.i_data  = v5;
    bus5.i_valid = 1'b1;
    @(negedge clock);
    bus5.i_valid = 1'b0;
    lat = 1;
    while (!bus5.o_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check("n5_latency", lat, 4);
    check("n5_data", bus5.o_data, 19);
    @(negedge clock);

    // Asynchronous reset in the middle of MAC.
    send12(fill12(8'd1));
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("midrst_busy",  bus12.o_busy,  0);
    check("midrst_ready", bus12.o_ready, 0);
    check("midrst_valid", bus12.o_valid, 0);
    check("midrst_data",  bus12.o_data,  0);
    @(negedge clock);
    reset = 1'b1;
    run12("after_reset_ones", fill12(8'd1), 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
